// File: rtl/pipeline_stall_sequencer_if.sv
// Hazard and memory-status signals from the pipeline, and the stage enables,
// bubbles, flushes and status returned by the stall sequencer.
interface pipeline_stall_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ID_EX_MemRead;
    logic [4:0]           ID_EX_RegRt;
    logic [4:0]           IF_ID_RegRs;
    logic [4:0]           IF_ID_RegRt;
    logic                 EX_MEM_branch;
    logic                 EX_MEM_jump;
    logic                 EX_MEM_ALU_Zero;
    logic                 EX_MEM_MemRead;
    logic                 EX_MEM_MemWrite;
    logic                 dmem_ready;

    logic                 PCWrite;
    logic                 IF_ID_Write;
    logic                 ID_EX_Write;
    logic                 EX_MEM_Write;
    logic                 Mux_Select_Stall;
    logic                 IF_Flush;
    logic                 ID_Flush;
    logic                 EX_Flush;
    logic                 MEM_WB_Bubble;
    logic                 dmem_req;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt,
               EX_MEM_branch, EX_MEM_jump, EX_MEM_ALU_Zero,
               EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
        input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
               Mux_Select_Stall, IF_Flush, ID_Flush, EX_Flush,
               MEM_WB_Bubble, dmem_req, mem_timeout, stall_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt,
               EX_MEM_branch, EX_MEM_jump, EX_MEM_ALU_Zero,
               EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
        output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
               Mux_Select_Stall, IF_Flush, ID_Flush, EX_Flush,
               MEM_WB_Bubble, dmem_req, mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline: memory waits,
// branch/jump redirects and load-use interlock, with timeout and stall counter.
//
// state    | meaning
// RUN      | no outstanding memory wait
// MEM_WAIT | data memory access stalled, counting wait cycles
// MEM_ERR  | memory never responded; pipeline frozen until reset
module pipeline_stall_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input logic                       clk,
    input logic                       rst,
    pipeline_stall_sequencer_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WW-1:0]        wait_cnt;
    logic [WW-1:0]        wait_nxt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    logic mem_op;
    logic mem_stall;
    logic redirect;
    logic load_use;
    logic stall_inc;

    assign mem_op    = bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite;
    assign mem_stall = mem_op & ~bus.dmem_ready & (state != MEM_ERR);
    assign redirect  = (bus.EX_MEM_branch & bus.EX_MEM_ALU_Zero) | bus.EX_MEM_jump;
    assign load_use  = bus.ID_EX_MemRead & (bus.ID_EX_RegRt != 5'd0) &
                       ((bus.ID_EX_RegRt == bus.IF_ID_RegRs) |
                        (bus.ID_EX_RegRt == bus.IF_ID_RegRt));

    // Only memory stalls and load-use interlocks count; redirects are not stalls.
    assign stall_inc = ~rst & (state != MEM_ERR) & (mem_stall | (~redirect & load_use));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    if (TIMEOUT_CYCLES <= 1) begin
                        state_nxt = MEM_ERR;
                    end else begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = WW'(1);
                    end
                end
            end
            MEM_WAIT: begin
                // Completion takes precedence over a timeout in the same cycle.
                if (!mem_stall) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = MEM_ERR;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            MEM_ERR: begin
                state_nxt = MEM_ERR;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        bus.PCWrite          = 1'b0;
        bus.IF_ID_Write      = 1'b0;
        bus.ID_EX_Write      = 1'b0;
        bus.EX_MEM_Write     = 1'b0;
        bus.Mux_Select_Stall = 1'b0;
        bus.IF_Flush         = 1'b0;
        bus.ID_Flush         = 1'b0;
        bus.EX_Flush         = 1'b0;
        bus.MEM_WB_Bubble    = 1'b0;
        bus.dmem_req         = 1'b0;
        bus.mem_timeout      = 1'b0;
        if (rst) begin
            bus.PCWrite = 1'b0;
        end else if (state == MEM_ERR) begin
            bus.MEM_WB_Bubble = 1'b1;
            bus.mem_timeout   = 1'b1;
        end else begin
            bus.dmem_req = mem_op;
            if (mem_stall) begin
                bus.MEM_WB_Bubble = 1'b1;
            end else if (redirect) begin
                bus.PCWrite      = 1'b1;
                bus.IF_ID_Write  = 1'b1;
                bus.ID_EX_Write  = 1'b1;
                bus.EX_MEM_Write = 1'b1;
                bus.IF_Flush     = 1'b1;
                bus.ID_Flush     = 1'b1;
                bus.EX_Flush     = 1'b1;
            end else if (load_use) begin
                bus.Mux_Select_Stall = 1'b1;
                bus.ID_EX_Write      = 1'b1;
                bus.EX_MEM_Write     = 1'b1;
            end else begin
                bus.PCWrite      = 1'b1;
                bus.IF_ID_Write  = 1'b1;
                bus.ID_EX_Write  = 1'b1;
                bus.EX_MEM_Write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer: vector table for single-cycle
// priority cases, plus sequences for memory wait, timeout, reset and saturation.
module tb_pipeline_stall_sequencer;
    localparam int T_CYC = 4;
    localparam int CW    = 4;

    // {PCWrite,IF_ID_Write,ID_EX_Write,EX_MEM_Write,Mux,IF_Fl,ID_Fl,EX_Fl,Bubble,dmem_req,timeout}
    localparam logic [10:0] O_ZERO     = 11'b0000_0_000_0_0_0;
    localparam logic [10:0] O_IDLE     = 11'b1111_0_000_0_0_0;
    localparam logic [10:0] O_IDLE_REQ = 11'b1111_0_000_0_1_0;
    localparam logic [10:0] O_LU       = 11'b0011_1_000_0_0_0;
    localparam logic [10:0] O_LU_REQ   = 11'b0011_1_000_0_1_0;
    localparam logic [10:0] O_FLUSH    = 11'b1111_0_111_0_0_0;
    localparam logic [10:0] O_STALL    = 11'b0000_0_000_1_1_0;
    localparam logic [10:0] O_ERR      = 11'b0000_0_000_1_0_1;

    typedef struct {
        string       name;
        logic        mrd;
        logic [4:0]  ex_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        br;
        logic        jmp;
        logic        zero;
        logic        ex_rd;
        logic        ex_wr;
        logic        rdy;
        logic [10:0] exp_out;
        logic [3:0]  exp_cnt;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst;
    int     checks = 0;
    int     errors = 0;
    vec_t   vq[$];

    pipeline_stall_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    pipeline_stall_sequencer #(.TIMEOUT_CYCLES(T_CYC), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {bus.PCWrite, bus.IF_ID_Write, bus.ID_EX_Write, bus.EX_MEM_Write,
                bus.Mux_Select_Stall, bus.IF_Flush, bus.ID_Flush, bus.EX_Flush,
                bus.MEM_WB_Bubble, bus.dmem_req, bus.mem_timeout};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic mrd, input logic [4:0] ex_rt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic jmp,
                          input logic zero, input logic ex_rd, input logic ex_wr,
                          input logic rdy);
        bus.ID_EX_MemRead   = mrd;
        bus.ID_EX_RegRt     = ex_rt;
        bus.IF_ID_RegRs     = rs;
        bus.IF_ID_RegRt     = rt;
        bus.EX_MEM_branch   = br;
        bus.EX_MEM_jump     = jmp;
        bus.EX_MEM_ALU_Zero = zero;
        bus.EX_MEM_MemRead  = ex_rd;
        bus.EX_MEM_MemWrite = ex_wr;
        bus.dmem_ready      = rdy;
    endtask

    task automatic clear_in();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input string n, input logic mrd, input logic [4:0] ex_rt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic jmp, input logic zero, input logic ex_rd,
                       input logic ex_wr, input logic rdy, input logic [10:0] eo,
                       input logic [3:0] ec);
        vec_t v;
        v.name = n; v.mrd = mrd; v.ex_rt = ex_rt; v.rs = rs; v.rt = rt;
        v.br = br; v.jmp = jmp; v.zero = zero; v.ex_rd = ex_rd; v.ex_wr = ex_wr;
        v.rdy = rdy; v.exp_out = eo; v.exp_cnt = ec;
        vq.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        add("idle",          0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, O_IDLE,     4'd0);
        add("lu_rs",         1, 5'd5, 5'd5, 5'd3, 0, 0, 0, 0, 0, 0, O_LU,       4'd1);
        add("lu_rt",         1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 0, 0, O_LU,       4'd1);
        add("lu_r0",         1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, O_IDLE,     4'd0);
        add("no_load",       0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, 0, O_IDLE,     4'd0);
        add("br_taken",      0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, O_FLUSH,    4'd0);
        add("br_not_taken",  0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, O_IDLE,     4'd0);
        add("jump_over_lu",  1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, 0, 0, O_FLUSH,    4'd0);
        add("load_ready",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, O_IDLE_REQ, 4'd0);
        add("store_stall",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, O_STALL,    4'd1);
        add("stall_over_all",1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 1, 0, 0, O_STALL,    4'd1);
        add("ready_lu",      1, 5'd9, 5'd2, 5'd9, 0, 0, 0, 1, 0, 1, O_LU_REQ,   4'd1);

        // Outputs held at zero during reset even with active hazards.
        rst = 1'b1;
        set_in(1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_outs", 32'(outs()), 32'(O_ZERO));
        check("rst_cnt", 32'(bus.stall_count), 32'd0);
        clear_in();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_outs", 32'(outs()), 32'(O_IDLE));
        check("post_rst_cnt", 32'(bus.stall_count), 32'd0);

        foreach (vq[i]) begin
            do_reset();
            set_in(vq[i].mrd, vq[i].ex_rt, vq[i].rs, vq[i].rt, vq[i].br, vq[i].jmp,
                   vq[i].zero, vq[i].ex_rd, vq[i].ex_wr, vq[i].rdy);
            #1;
            check({vq[i].name, "_outs"}, 32'(outs()), 32'(vq[i].exp_out));
            @(posedge clk);
            #1;
            check({vq[i].name, "_cnt"}, 32'(bus.stall_count), 32'(vq[i].exp_cnt));
        end

        // Two back-to-back memory waits of three cycles each.
        do_reset();
        for (int w = 0; w < 2; w++) begin
            set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
            for (int c = 0; c < 3; c++) begin
                #1;
                check($sformatf("wait%0d_c%0d", w, c), 32'(outs()), 32'(O_STALL));
                @(negedge clk);
            end
            bus.dmem_ready = 1'b1;
            #1;
            check($sformatf("wait%0d_done", w), 32'(outs()), 32'(O_IDLE_REQ));
            @(negedge clk);
            clear_in();
            #1;
            check($sformatf("wait%0d_cnt", w), 32'(bus.stall_count), 32'(3 * (w + 1)));
            check($sformatf("wait%0d_idle", w), 32'(outs()), 32'(O_IDLE));
        end

        // Timeout after exactly T_CYC stalled cycles, sticky afterwards.
        do_reset();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        for (int c = 0; c < T_CYC; c++) begin
            #1;
            check($sformatf("to_stall_c%0d", c), 32'(outs()), 32'(O_STALL));
            @(negedge clk);
        end
        #1;
        check("to_err", 32'(outs()), 32'(O_ERR));
        check("to_cnt", 32'(bus.stall_count), 32'(T_CYC));
        bus.dmem_ready = 1'b1;
        #1;
        check("to_late_ready", 32'(outs()), 32'(O_ERR));
        @(negedge clk);
        @(negedge clk);
        #1;
        check("to_sticky", 32'(outs()), 32'(O_ERR));
        check("to_sticky_cnt", 32'(bus.stall_count), 32'(T_CYC));

        // Reset in the middle of a wait restarts the full timeout window.
        do_reset();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outs", 32'(outs()), 32'(O_ZERO));
        check("midrst_cnt", 32'(bus.stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < T_CYC; c++) begin
            #1;
            check($sformatf("rerun_stall_c%0d", c), 32'(outs()), 32'(O_STALL));
            @(negedge clk);
        end
        #1;
        check("rerun_err", 32'(outs()), 32'(O_ERR));

        // Saturation of the stall counter under continuous load-use.
        do_reset();
        set_in(1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            #1;
            if (c == 14 || c == 15)
                check($sformatf("sat_cnt_%0d", c), 32'(bus.stall_count), 32'(c));
        end
        check("sat_final", 32'(bus.stall_count), 32'd15);
        check("sat_outs", 32'(outs()), 32'(O_LU));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
